// File: rtl/double_tokens.sv
// Serial token expander: each accepted '1' on a owes FACTOR tokens on b,
// emitted one per cycle from a saturating pending counter with sticky overflow.
module double_tokens #(
    parameter int FACTOR      = 2,
    parameter int MAX_PENDING = 200,
    parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             hold,
    input  logic             ovf_clr,
    output logic             b,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow
);

    // Headroom so pending + FACTOR (FACTOR <= 15) never wraps before the compare.
    localparam int SUM_W = CNT_W + 5;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SUM_W-1:0] sum;
    logic             sat;
    logic [CNT_W-1:0] pending_nxt;
    logic             overflow_nxt;

    // DRAIN is held exactly when the registered pending count is non-zero.
    always_comb begin
        busy = (state == DRAIN);
        b    = !hold && (busy || a);
    end

    always_comb begin
        sum = SUM_W'(pending);
        if (a) begin
            sum = sum + SUM_W'(FACTOR);
        end
        if (b) begin
            sum = sum - SUM_W'(1);
        end
        sat = (sum > SUM_W'(MAX_PENDING));
        if (sat) begin
            pending_nxt = CNT_W'(MAX_PENDING);
        end else begin
            pending_nxt = sum[CNT_W-1:0];
        end
        // Set beats clear when both happen in the same cycle.
        overflow_nxt = sat || (overflow && !ovf_clr);
    end

    // NOTE: every variable written in a combinational block gets a value on
    // every path (default first), otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending_nxt != '0) state_nxt = DRAIN;
            DRAIN:   if (pending_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
        end
    end

endmodule
